// File: rtl/edge_bbox_tracker.sv
// Per-frame edge statistics downstream of the edge detector: edge-pixel count and bounding box,
// latched once per frame at the falling edge of vertical sync.
module edge_bbox_tracker #(
  parameter int unsigned PIPE_DELAY = 4,
  parameter int unsigned ACTIVE_W   = 640,
  parameter int unsigned ACTIVE_H   = 480,
  parameter int unsigned MARGIN     = 2,
  parameter int unsigned MIN_COUNT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_vs_i,
  input  logic        pix_valid_i,
  input  logic [9:0]  addr_x_i,
  input  logic [9:0]  addr_y_i,
  input  logic        edge_in_i,
  output logic        bbox_valid_o,
  output logic        box_found_o,
  output logic [9:0]  x_min_o,
  output logic [9:0]  x_max_o,
  output logic [9:0]  y_min_o,
  output logic [9:0]  y_max_o,
  output logic [18:0] edge_count_o
);

  localparam logic [10:0] XLo    = 11'(MARGIN);
  localparam logic [10:0] XHi    = 11'(ACTIVE_W - MARGIN);
  localparam logic [10:0] YLo    = 11'(MARGIN);
  localparam logic [10:0] YHi    = 11'(ACTIVE_H - MARGIN);
  localparam logic [18:0] MinCnt = 19'(MIN_COUNT);
  localparam logic [18:0] CntMax = 19'h7FFFF;

  typedef enum logic [1:0] {StWaitSync, StAccum, StReport} state_e;

  state_e state_q, state_d;

  // Address pipe: realigns the pixel address with the late edge flag.
  logic       pipe_v_q [PIPE_DELAY];
  logic [9:0] pipe_x_q [PIPE_DELAY];
  logic [9:0] pipe_y_q [PIPE_DELAY];

  logic vs_d_q;
  logic vs_fall;
  logic qual;

  logic [9:0]  acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
  logic [9:0]  acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
  logic [18:0] cnt_q, cnt_d;

  logic        bbox_valid_q, bbox_valid_d;
  logic        box_found_q, box_found_d;
  logic [9:0]  x_min_q, x_min_d, x_max_q, x_max_d;
  logic [9:0]  y_min_q, y_min_d, y_max_q, y_max_d;
  logic [18:0] edge_count_q, edge_count_d;

  logic [9:0] dly_x, dly_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_DELAY; i++) begin
        pipe_v_q[i] <= 1'b0;
        pipe_x_q[i] <= '0;
        pipe_y_q[i] <= '0;
      end
    end else begin
      pipe_v_q[0] <= pix_valid_i;
      pipe_x_q[0] <= addr_x_i;
      pipe_y_q[0] <= addr_y_i;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_x_q[i] <= pipe_x_q[i-1];
        pipe_y_q[i] <= pipe_y_q[i-1];
      end
    end
  end

  assign dly_x   = pipe_x_q[PIPE_DELAY-1];
  assign dly_y   = pipe_y_q[PIPE_DELAY-1];
  assign qual    = pipe_v_q[PIPE_DELAY-1] & edge_in_i &
                   ({1'b0, dly_x} >= XLo) & ({1'b0, dly_x} < XHi) &
                   ({1'b0, dly_y} >= YLo) & ({1'b0, dly_y} < YHi);
  assign vs_fall = vs_d_q & ~vga_vs_i;

  always_comb begin
    logic init;
    init         = 1'b0;
    state_d      = state_q;
    acc_xmin_d   = acc_xmin_q;
    acc_xmax_d   = acc_xmax_q;
    acc_ymin_d   = acc_ymin_q;
    acc_ymax_d   = acc_ymax_q;
    cnt_d        = cnt_q;
    bbox_valid_d = 1'b0;
    box_found_d  = box_found_q;
    x_min_d      = x_min_q;
    x_max_d      = x_max_q;
    y_min_d      = y_min_q;
    y_max_d      = y_max_q;
    edge_count_d = edge_count_q;

    unique case (state_q)
      StWaitSync: begin
        if (vs_fall) begin
          state_d = StAccum;
          init    = 1'b1;
        end
      end
      StAccum: begin
        if (vs_fall) begin
          state_d = StReport;
        end else if (qual) begin
          cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 19'd1;
          if (dly_x <= acc_xmin_q) acc_xmin_d = dly_x;
          if (dly_x >= acc_xmax_q) acc_xmax_d = dly_x;
          if (dly_y <= acc_ymin_q) acc_ymin_d = dly_y;
          if (dly_y >= acc_ymax_q) acc_ymax_d = dly_y;
        end
      end
      StReport: begin
        // Any vs_fall here is ignored; a real sync pulse spans many lines.
        bbox_valid_d = 1'b1;
        edge_count_d = cnt_q;
        box_found_d  = (cnt_q >= MinCnt);
        x_min_d      = (cnt_q >= MinCnt) ? acc_xmin_q : 10'd0;
        x_max_d      = (cnt_q >= MinCnt) ? acc_xmax_q : 10'd0;
        y_min_d      = (cnt_q >= MinCnt) ? acc_ymin_q : 10'd0;
        y_max_d      = (cnt_q >= MinCnt) ? acc_ymax_q : 10'd0;
        init         = 1'b1;
        state_d      = StAccum;
      end
      default: state_d = StWaitSync;
    endcase

    if (init) begin
      acc_xmin_d = 10'd1023;
      acc_xmax_d = 10'd0;
      acc_ymin_d = 10'd1023;
      acc_ymax_d = 10'd0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StWaitSync;
      vs_d_q       <= 1'b0;
      acc_xmin_q   <= 10'd1023;
      acc_xmax_q   <= 10'd0;
      acc_ymin_q   <= 10'd1023;
      acc_ymax_q   <= 10'd0;
      cnt_q        <= '0;
      bbox_valid_q <= 1'b0;
      box_found_q  <= 1'b0;
      x_min_q      <= '0;
      x_max_q      <= '0;
      y_min_q      <= '0;
      y_max_q      <= '0;
      edge_count_q <= '0;
    end else begin
      state_q      <= state_d;
      vs_d_q       <= vga_vs_i;
      acc_xmin_q   <= acc_xmin_d;
      acc_xmax_q   <= acc_xmax_d;
      acc_ymin_q   <= acc_ymin_d;
      acc_ymax_q   <= acc_ymax_d;
      cnt_q        <= cnt_d;
      bbox_valid_q <= bbox_valid_d;
      box_found_q  <= box_found_d;
      x_min_q      <= x_min_d;
      x_max_q      <= x_max_d;
      y_min_q      <= y_min_d;
      y_max_q      <= y_max_d;
      edge_count_q <= edge_count_d;
    end
  end

  assign bbox_valid_o = bbox_valid_q;
  assign box_found_o  = box_found_q;
  assign x_min_o      = x_min_q;
  assign x_max_o      = x_max_q;
  assign y_min_o      = y_min_q;
  assign y_max_o      = y_max_q;
  assign edge_count_o = edge_count_q;

endmodule

// File: tb/tb_edge_bbox_tracker.sv
// Directed bench for edge_bbox_tracker: three instances share stimulus (default, no-margin with
// MIN_COUNT=1, and a small 16x8 frame) and are checked against hand-computed frame results.
module tb_edge_bbox_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       vga_vs;
  logic       pix_valid;
  logic [9:0] addr_x, addr_y;
  logic       edge_in;

  logic        bv  [3];
  logic        bf  [3];
  logic [9:0]  xmn [3];
  logic [9:0]  xmx [3];
  logic [9:0]  ymn [3];
  logic [9:0]  ymx [3];
  logic [18:0] cnt [3];

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic       vs    = 1'b1;
  logic       undel = 1'b0;
  logic [3:0] esr   = '0;

  always #5 clk = ~clk;

  edge_bbox_tracker dut_a (
    .clk(clk), .reset(reset), .vga_vs_i(vga_vs), .pix_valid_i(pix_valid),
    .addr_x_i(addr_x), .addr_y_i(addr_y), .edge_in_i(edge_in),
    .bbox_valid_o(bv[0]), .box_found_o(bf[0]), .x_min_o(xmn[0]), .x_max_o(xmx[0]),
    .y_min_o(ymn[0]), .y_max_o(ymx[0]), .edge_count_o(cnt[0])
  );

  edge_bbox_tracker #(.MARGIN(0), .MIN_COUNT(1)) dut_b (
    .clk(clk), .reset(reset), .vga_vs_i(vga_vs), .pix_valid_i(pix_valid),
    .addr_x_i(addr_x), .addr_y_i(addr_y), .edge_in_i(edge_in),
    .bbox_valid_o(bv[1]), .box_found_o(bf[1]), .x_min_o(xmn[1]), .x_max_o(xmx[1]),
    .y_min_o(ymn[1]), .y_max_o(ymx[1]), .edge_count_o(cnt[1])
  );

  edge_bbox_tracker #(.ACTIVE_W(16), .ACTIVE_H(8), .MARGIN(0), .MIN_COUNT(1)) dut_c (
    .clk(clk), .reset(reset), .vga_vs_i(vga_vs), .pix_valid_i(pix_valid),
    .addr_x_i(addr_x), .addr_y_i(addr_y), .edge_in_i(edge_in),
    .bbox_valid_o(bv[2]), .box_found_o(bf[2]), .x_min_o(xmn[2]), .x_max_o(xmx[2]),
    .y_min_o(ymn[2]), .y_max_o(ymx[2]), .edge_count_o(cnt[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // edge_in is the edge flag of the pixel presented PIPE_DELAY=4 steps earlier.
  task automatic step(input logic v, input logic [9:0] x, input logic [9:0] y, input logic e);
    pix_valid = v;
    addr_x    = x;
    addr_y    = y;
    vga_vs    = vs;
    edge_in   = undel ? e : esr[3];
    esr       = {esr[2:0], (undel ? 1'b0 : e)};
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'd0, 10'd0, 1'b0);
  endtask

  task automatic rect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) step(1'b1, 10'(x), 10'(y), 1'b1);
  endtask

  task automatic vs_pulse(input string tag, input logic rep);
    idle(6);
    vs = 1'b0;
    step(1'b0, 10'd0, 10'd0, 1'b0);
    chk({tag, "_bv_n"}, 32'(bv[0]), 32'd0);
    step(1'b0, 10'd0, 10'd0, 1'b0);
    for (int d = 0; d < 3; d++) chk($sformatf("%s_bv_n1_%0d", tag, d), 32'(bv[d]), 32'(rep));
    step(1'b0, 10'd0, 10'd0, 1'b0);
    chk({tag, "_bv_n2"}, 32'(bv[0]), 32'd0);
    vs = 1'b1;
    idle(3);
  endtask

  task automatic chk_frame(input string tag, input int d, input int c, input logic f,
                           input int x0, input int x1, input int y0, input int y1);
    chk($sformatf("%s_cnt_%0d", tag, d),   32'(cnt[d]), 32'(c));
    chk($sformatf("%s_found_%0d", tag, d), 32'(bf[d]),  32'(f));
    chk($sformatf("%s_xmin_%0d", tag, d),  32'(xmn[d]), 32'(x0));
    chk($sformatf("%s_xmax_%0d", tag, d),  32'(xmx[d]), 32'(x1));
    chk($sformatf("%s_ymin_%0d", tag, d),  32'(ymn[d]), 32'(y0));
    chk($sformatf("%s_ymax_%0d", tag, d),  32'(ymx[d]), 32'(y1));
  endtask

  initial begin
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    chk("rst_bv", 32'(bv[0]), 32'd0);
    for (int d = 0; d < 3; d++) chk_frame("rst", d, 0, 1'b0, 0, 0, 0, 0);

    // 1: first vsync only arms the tracker; second reports an empty frame.
    vs_pulse("t1a", 1'b0);
    vs_pulse("t1b", 1'b1);
    chk_frame("t1", 0, 0, 1'b0, 0, 0, 0, 0);

    // 2: 10x10 square.
    rect(100, 109, 50, 59);
    vs_pulse("t2", 1'b1);
    chk_frame("t2", 0, 100, 1'b1, 100, 109, 50, 59);
    chk_frame("t2", 1, 100, 1'b1, 100, 109, 50, 59);
    chk_frame("t2", 2, 0, 1'b0, 0, 0, 0, 0);

    // 3: border pixels dropped by the margin, inner corners kept.
    rect(200, 267, 100, 100);
    step(1'b1, 10'd2,   10'd2,   1'b1);
    step(1'b1, 10'd637, 10'd477, 1'b1);
    step(1'b1, 10'd0,   10'd20,  1'b1);
    step(1'b1, 10'd1,   10'd20,  1'b1);
    step(1'b1, 10'd50,  10'd479, 1'b1);
    step(1'b1, 10'd638, 10'd300, 1'b1);
    step(1'b1, 10'd300, 10'd1,   1'b1);
    step(1'b1, 10'd300, 10'd478, 1'b1);
    vs_pulse("t3", 1'b1);
    chk_frame("t3", 0, 70, 1'b1, 2, 637, 2, 477);
    chk_frame("t3", 1, 76, 1'b1, 0, 638, 1, 479);
    chk_frame("t3", 2, 1, 1'b1, 2, 2, 2, 2);

    // MIN_COUNT boundary: 63 edges is not enough.
    rect(10, 72, 10, 10);
    vs_pulse("t3b", 1'b1);
    chk_frame("t3b", 0, 63, 1'b0, 0, 0, 0, 0);
    chk_frame("t3b", 1, 63, 1'b1, 10, 72, 10, 10);

    // 4: single pixel, properly delayed, then fed undelayed.
    step(1'b1, 10'd320, 10'd240, 1'b1);
    vs_pulse("t4a", 1'b1);
    chk_frame("t4a", 0, 1, 1'b0, 0, 0, 0, 0);
    chk_frame("t4a", 1, 1, 1'b1, 320, 320, 240, 240);
    undel = 1'b1;
    for (int x = 316; x <= 330; x++) step(1'b1, 10'(x), 10'd240, 1'(x == 320));
    undel = 1'b0;
    vs_pulse("t4b", 1'b1);
    chk_frame("t4b", 1, 1, 1'b1, 316, 316, 240, 240);
    chk("t4b_cnt_0", 32'(cnt[0]), 32'd1);

    // 5: reset mid-frame after 500 edges.
    rect(100, 599, 200, 200);
    reset = 1'b1;
    esr   = '0;
    idle(2);
    reset = 1'b0;
    idle(1);
    chk_frame("t5rst", 0, 0, 1'b0, 0, 0, 0, 0);
    chk_frame("t5rst", 1, 0, 1'b0, 0, 0, 0, 0);
    rect(400, 409, 300, 300);
    vs_pulse("t5a", 1'b0);
    rect(150, 229, 60, 60);
    vs_pulse("t5b", 1'b1);
    chk_frame("t5", 0, 80, 1'b1, 150, 229, 60, 60);
    chk_frame("t5", 1, 80, 1'b1, 150, 229, 60, 60);
    chk_frame("t5", 2, 0, 1'b0, 0, 0, 0, 0);

    // 6: every pixel of the 16x8 frame is an edge, two frames in a row.
    for (int f = 0; f < 2; f++) begin
      rect(0, 19, 0, 8);
      vs_pulse($sformatf("t6_%0d", f), 1'b1);
      chk_frame($sformatf("t6_%0d", f), 2, 128, 1'b1, 0, 15, 0, 7);
      chk_frame($sformatf("t6_%0d", f), 0, 126, 1'b1, 2, 19, 2, 8);
      chk_frame($sformatf("t6_%0d", f), 1, 180, 1'b1, 0, 19, 0, 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
